// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: oversampled SCL/SDA, START/STOP detection, address match,
// ACK of matching writes and a one-cycle strobe per received data byte.
module i2c_target_rx #(
   parameter logic [6:0]  ADDR        = 7'h50,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i2c_scl,
   input  logic       i2c_sda_in,
   output logic       i2c_sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addr_hit,
   output logic       stop_det,
   output logic       busy
);

   typedef enum logic [2:0] {StIdle, StAddr, StAckA, StData, StAckD, StIgnore} state_e;

   // Synchroniser chains preset to 1 so reset release looks like an idle bus
   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic                   r_scl, r_sda;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl      <= 1'b1;
         r_sda      <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sda_in};
         r_scl      <= r_scl_sync[SYNC_STAGES-1];
         r_sda      <= r_sda_sync[SYNC_STAGES-1];
      end
   end

   logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl;
   assign w_scl_fall = ~w_scl & r_scl;
   assign w_start    = w_scl & r_scl & r_sda & ~w_sda;
   assign w_stop     = w_scl & r_scl & ~r_sda & w_sda;

   state_e     r_state, w_state_nxt;
   logic [2:0] r_cnt, w_cnt_nxt;
   logic [7:0] r_shift, w_shift_nxt, w_byte;
   logic       r_ack_drv, w_ack_drv_nxt;
   logic       r_sda_oe, w_sda_oe_nxt;
   logic [7:0] r_rx_data, w_rx_data_nxt;
   logic       r_rx_valid, w_rx_valid_nxt;
   logic       r_addr_hit, w_addr_hit_nxt;
   logic       r_stop_det, w_stop_det_nxt;
   logic       r_busy, w_busy_nxt;

   assign w_byte = {r_shift[6:0], w_sda};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_cnt      <= 3'd7;
         r_shift    <= 8'h00;
         r_ack_drv  <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_addr_hit <= 1'b0;
         r_stop_det <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_ack_drv  <= w_ack_drv_nxt;
         r_sda_oe   <= w_sda_oe_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_rx_valid <= w_rx_valid_nxt;
         r_addr_hit <= w_addr_hit_nxt;
         r_stop_det <= w_stop_det_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_shift_nxt    = r_shift;
      w_ack_drv_nxt  = r_ack_drv;
      w_sda_oe_nxt   = r_sda_oe;
      w_rx_data_nxt  = r_rx_data;
      w_rx_valid_nxt = 1'b0;
      w_addr_hit_nxt = r_addr_hit;
      w_stop_det_nxt = 1'b0;
      w_busy_nxt     = r_busy;

      // Bus conditions override whatever the byte/ACK machinery is doing
      if (w_stop) begin
         w_state_nxt    = StIdle;
         w_sda_oe_nxt   = 1'b0;
         w_ack_drv_nxt  = 1'b0;
         w_addr_hit_nxt = 1'b0;
         w_busy_nxt     = 1'b0;
         w_stop_det_nxt = 1'b1;
      end else if (w_start) begin
         w_state_nxt    = StAddr;
         w_cnt_nxt      = 3'd7;
         w_sda_oe_nxt   = 1'b0;
         w_ack_drv_nxt  = 1'b0;
         w_addr_hit_nxt = 1'b0;
         w_busy_nxt     = 1'b1;
      end else begin
         case (r_state)
            StAddr, StData: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_byte;
                  if (r_cnt == 3'd0) begin
                     w_ack_drv_nxt = 1'b0;
                     if (r_state == StAddr) begin
                        w_state_nxt = (w_byte[7:1] == ADDR && !w_byte[0]) ? StAckA : StIgnore;
                     end else begin
                        w_rx_data_nxt  = w_byte;
                        w_rx_valid_nxt = 1'b1;
                        w_state_nxt    = StAckD;
                     end
                  end else begin
                     w_cnt_nxt = r_cnt - 3'd1;
                  end
               end
            end
            // First falling edge grabs SDA, the next one (end of 9th clock) lets go
            StAckA, StAckD: begin
               if (w_scl_fall) begin
                  if (!r_ack_drv) begin
                     w_sda_oe_nxt  = 1'b1;
                     w_ack_drv_nxt = 1'b1;
                  end else begin
                     w_sda_oe_nxt  = 1'b0;
                     w_ack_drv_nxt = 1'b0;
                     w_cnt_nxt     = 3'd7;
                     w_state_nxt   = StData;
                     if (r_state == StAckA) w_addr_hit_nxt = 1'b1;
                  end
               end
            end
            StIgnore: w_sda_oe_nxt = 1'b0;
            StIdle:   w_sda_oe_nxt = 1'b0;
            default:  w_state_nxt  = StIdle;
         endcase
      end
   end

   assign i2c_sda_oe = r_sda_oe;
   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign addr_hit   = r_addr_hit;
   assign stop_det   = r_stop_det;
   assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: drives I2C write frames through an open-drain bus
// model and compares ACKs, received bytes and status pulses against a transaction-level model.
module tb_i2c_target_rx;

   localparam logic [6:0] DevAddr = 7'h50;

   logic       clk, rst;
   logic       scl_drv, sda_drv;
   logic       i2c_sda_in, i2c_sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid, addr_hit, stop_det, busy;

   assign i2c_sda_in = sda_drv & ~i2c_sda_oe;

   i2c_target_rx #(.ADDR(DevAddr), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .i2c_scl    (scl_drv),
      .i2c_sda_in (i2c_sda_in),
      .i2c_sda_oe (i2c_sda_oe),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .addr_hit   (addr_hit),
      .stop_det   (stop_det),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] got_q[$];
   logic [7:0] tx_q[$];
   logic [7:0] m_rx_data;
   int         n_stop;
   bit         oe_seen;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Bus monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         if (rx_valid)   got_q.push_back(rx_data);
         if (stop_det)   n_stop++;
         if (i2c_sda_oe) oe_seen = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every bus task leaves SCL low, 5 clk into the low phase (except stop, which idles the bus)
   task automatic i2c_start();
      sda_drv = 1'b1; scl_drv = 1'b1; tick(10);
      sda_drv = 1'b0; tick(10);
      scl_drv = 1'b0; tick(5);
   endtask

   task automatic i2c_rstart();
      sda_drv = 1'b1; tick(5);
      scl_drv = 1'b1; tick(10);
      sda_drv = 1'b0; tick(10);
      scl_drv = 1'b0; tick(5);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; tick(5);
      scl_drv = 1'b1; tick(10);
      sda_drv = 1'b1; tick(10);
   endtask

   task automatic send_bit(input logic b);
      sda_drv = b; tick(5);
      scl_drv = 1'b1; tick(10);
      scl_drv = 1'b0; tick(5);
   endtask

   task automatic ack_bit(output logic oe);
      sda_drv = 1'b1; tick(5);
      scl_drv = 1'b1; tick(5);
      oe = i2c_sda_oe;
      tick(5);
      scl_drv = 1'b0; tick(5);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic oe);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      ack_bit(oe);
   endtask

   // One complete write frame of tx_q; expectations come from the address rule alone
   task automatic run_write(input logic [6:0] a, input logic rw);
      logic       oe;
      bit         exp_ack;
      logic [7:0] exp_q[$];
      int         stop0;
      exp_ack = (a == DevAddr) && (rw == 1'b0);
      exp_q   = {};
      if (exp_ack) foreach (tx_q[i]) exp_q.push_back(tx_q[i]);
      got_q   = {};
      oe_seen = 1'b0;
      stop0   = n_stop;
      i2c_start();
      check_eq("busy_in_frame", {31'd0, busy}, 32'd1);
      send_byte({a, rw}, oe);
      check_eq("addr_ack", {31'd0, oe}, {31'd0, exp_ack});
      foreach (tx_q[i]) begin
         send_byte(tx_q[i], oe);
         check_eq("data_ack", {31'd0, oe}, {31'd0, exp_ack});
         if (i == 0) check_eq("addr_hit", {31'd0, addr_hit}, {31'd0, exp_ack});
      end
      i2c_stop();
      tick(5);
      check_eq("busy_after_stop", {31'd0, busy}, 32'd0);
      check_eq("hit_after_stop", {31'd0, addr_hit}, 32'd0);
      check_eq("stop_pulses", n_stop - stop0, 32'd1);
      check_eq("rx_count", got_q.size(), exp_q.size());
      foreach (exp_q[i]) if (i < got_q.size()) check_eq("rx_byte", got_q[i], exp_q[i]);
      if (!exp_ack) check_eq("nack_oe_seen", {31'd0, oe_seen}, 32'd0);
      if (exp_q.size() > 0) m_rx_data = exp_q[exp_q.size()-1];
      check_eq("rx_data_hold", rx_data, m_rx_data);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_oe"}, {31'd0, i2c_sda_oe}, 32'd0);
      check_eq({tag, "_rx_data"}, rx_data, 32'd0);
      check_eq({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
      check_eq({tag, "_addr_hit"}, {31'd0, addr_hit}, 32'd0);
      check_eq({tag, "_stop_det"}, {31'd0, stop_det}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       oe;
      logic [6:0] a;
      logic       rw;
      int         stop0;
      rst = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
      m_rx_data = 8'h00; n_stop = 0;
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b1;
      tick(5);

      tx_q = {8'h55};             run_write(7'h51, 1'b0);
      tx_q = {8'hAA};             run_write(7'h50, 1'b0);
      tx_q = {8'h3C};             run_write(7'h50, 1'b1);
      tx_q = {8'h12, 8'h34, 8'hFF}; run_write(7'h50, 1'b0);
      tx_q = {8'h00};             run_write(7'h00, 1'b0);

      // Partial byte cut off by a repeated START is dropped
      got_q = {}; stop0 = n_stop;
      i2c_start();
      send_byte({DevAddr, 1'b0}, oe);
      check_eq("rs_addr_ack", {31'd0, oe}, 32'd1);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      i2c_rstart();
      check_eq("rs_hit_cleared", {31'd0, addr_hit}, 32'd0);
      send_byte({DevAddr, 1'b0}, oe);
      check_eq("rs_addr_ack2", {31'd0, oe}, 32'd1);
      send_byte(8'hC3, oe);
      check_eq("rs_data_ack", {31'd0, oe}, 32'd1);
      i2c_stop(); tick(5);
      check_eq("rs_rx_count", got_q.size(), 32'd1);
      if (got_q.size() > 0) check_eq("rs_rx_byte", got_q[0], 32'hC3);
      check_eq("rs_stop_pulses", n_stop - stop0, 32'd1);
      m_rx_data = 8'hC3;

      for (int t = 0; t < 8; t++) begin
         a  = ($urandom_range(0, 2) != 0) ? DevAddr : 7'($urandom_range(0, 127));
         rw = ($urandom_range(0, 3) == 0);
         tx_q = {};
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) tx_q.push_back(8'($urandom));
         run_write(a, rw);
      end

      // Reset asserted while the target is driving the data ACK
      i2c_start();
      send_byte({DevAddr, 1'b0}, oe);
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h5A >> i));
      sda_drv = 1'b1; tick(5);
      scl_drv = 1'b1; tick(5);
      check_eq("ackd_oe_before_rst", {31'd0, i2c_sda_oe}, 32'd1);
      #2 rst = 1'b0;
      #1 check_reset_outputs("async_rst");
      #6 rst = 1'b1;
      @(negedge clk);
      got_q = {}; stop0 = n_stop; oe_seen = 1'b0;
      tick(4);
      scl_drv = 1'b0; tick(5);
      send_byte(8'h77, oe);
      check_eq("post_rst_nack", {31'd0, oe}, 32'd0);
      send_bit(1'b0);
      i2c_stop(); tick(5);
      check_eq("post_rst_rx_count", got_q.size(), 32'd0);
      check_eq("post_rst_oe_seen", {31'd0, oe_seen}, 32'd0);
      check_eq("post_rst_stop", n_stop - stop0, 32'd1);
      m_rx_data = 8'h00;
      check_eq("post_rst_rx_data", rx_data, 32'd0);

      tx_q = {8'($urandom), 8'($urandom)}; run_write(DevAddr, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_target_rx.md
# i2c_target_rx

Write-only I2C target (slave) receiver. Oversamples the bus on the system clock, detects START/STOP, matches a 7-bit device address (default 0x50), ACKs matching write transactions, and delivers each received data byte (e.g. 0xAA) on a one-cycle strobe. It is the bus-side counterpart of the team's I2C write initiator and sits in the target device's register front end.

## Interface
- ADDR, 7'h50, device address this target answers to.
- SYNC_STAGES, 2, flip-flop stages on the SCL/SDA input synchronisers (≥2).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- i2c_scl  in  1  bus clock, sampled (never used as a clock).
- i2c_sda_in  in  1  bus data as seen on the pad.
- i2c_sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- rx_data  out  8  last received data byte, MSB first on the bus.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- addr_hit  out  1  high from address ACK until next START/STOP.
- stop_det  out  1  one-cycle pulse on every STOP condition.
- busy  out  1  high between any START and the following STOP.

## Operation
- Inputs pass through SYNC_STAGES flops, then one more register; edges/conditions derived from last two registered samples.
- START: SDA 1→0 while SCL high. STOP: SDA 0→1 while SCL high. Both recognised in every state, including mid-byte and during ACK.
- Bits sampled on synchronised SCL rising edge; SDA changes only tolerated while SCL low.
- States:
  - IDLE: sda_oe=0. START → ADDR, bit counter=7, busy=1.
  - ADDR: shift 8 bits (7 address MSB first, then R/W). After 8th rising edge: address==ADDR and R/W==0 → ACK_A; else → IGNORE.
  - ACK_A: on next SCL falling edge assert sda_oe; hold through 9th SCL high; release on following falling edge, set addr_hit=1, → DATA, counter=7.
  - DATA: shift 8 bits; on 8th rising edge load rx_data, pulse rx_valid, → ACK_D.
  - ACK_D: same ACK drive as ACK_A; then → DATA (multi-byte writes supported, unlimited count).
  - IGNORE: sda_oe=0 permanently (NACK); wait for START or STOP.
- START in any non-IDLE state (repeated START): release sda_oe, clear addr_hit, → ADDR, counter=7.
- STOP in any state: release sda_oe, clear addr_hit, busy=0, pulse stop_det, → IDLE. A partially received byte is discarded (no rx_valid).
- Read requests (R/W=1) are never ACKed; no data is ever driven.
- General-call (0x00) not supported: treated as mismatch.

## Timing
- Reset (rst=0, async): state=IDLE, i2c_sda_oe=0, rx_data=8'h00, rx_valid=0, addr_hit=0, stop_det=0, busy=0; synchroniser flops preset to 1 (idle bus, no false START on release).
- Detection latency: SCL/SDA pin change visible to FSM SYNC_STAGES+1 cycles later; rx_valid asserts SYNC_STAGES+2 cycles after 8th data SCL rising edge at pin.
- Bus requirement: SCL high and low phases each ≥ SYNC_STAGES+3 clk cycles; SDA setup/hold around SCL edges ≥ 2 clk cycles. Faster buses are out of scope.
- sda_oe asserts SYNC_STAGES+2 cycles after 8th SCL falling edge at pin; deasserts the same delay after 9th falling edge.
- rx_valid, stop_det: exactly one clk cycle wide; rx_data stable until next rx_valid.
- Reset asserted mid-transaction: immediate release of SDA; after deassert, block waits in IDLE for a fresh START (current frame ignored).

## Test plan
- Write 0x50 + W, data 0xAA, STOP (SCL period 20 clk) -> ACK low on both 9th clocks, rx_data=0xAA with one rx_valid pulse, addr_hit 1 then 0, one stop_det pulse, busy low after STOP.
- Address 0x51 + W, data 0x55 -> sda_oe never asserted, no rx_valid, stop_det pulses, rx_data remains 0x00.
- Address 0x50 + R -> NACK (sda_oe stays 0), FSM in IGNORE until STOP, no rx_valid.
- Write 0x50 + W, bytes 0x12, 0x34, 0xFF -> three rx_valid pulses with rx_data 0x12, 0x34, 0xFF in order, ACK after each.
- Write 0x50 + W, 4 bits of data, repeated START, 0x50 + W, 0xC3, STOP -> partial byte discarded, single rx_valid with 0xC3.
- Assert rst during ACK_D with sda_oe=1 -> sda_oe=0 same cycle (async), all outputs at reset values; following bits ignored until next START.
